// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared constants for the MEM-stage SRAM controller:
// FSM encoding, address map and SRAM geometry.
package mem_stage_sram_ctrl_pkg;

  localparam int WORD_W          = 32;
  localparam int SRAM_AW         = 18;
  localparam int SRAM_DW         = 16;
  localparam int DEF_WAIT_CYCLES = 5;
  localparam int DEF_MEM_BASE    = 1024;
  localparam int CNT_W           = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACC_LO = 2'd1;
  localparam logic [1:0] ST_ACC_HI = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/mem_stage_sram_ctrl_phase_counter.sv
// Wait counter for one SRAM half-word phase.
// Clear wins over enable; tc flags the last cycle of a phase.
module sram_phase_counter
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: one 32-bit word
// as two half-word accesses on a 16-bit SRAM.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH      = WORD_W,
  parameter int SRAM_ADDR_WIDTH = SRAM_AW,
  parameter int SRAM_DATA_WIDTH = SRAM_DW,
  parameter int WAIT_CYCLES     = DEF_WAIT_CYCLES,
  parameter int MEM_BASE        = DEF_MEM_BASE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [WORD_WIDTH-1:0]      address,
  input  logic [WORD_WIDTH-1:0]      write_data,
  output logic [WORD_WIDTH-1:0]      read_data,
  output logic                       ready,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
  output logic                       sram_we_n
);

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic                  wr_q;
  logic                  wr_d;
  logic [WORD_WIDTH-1:0] read_data_q;
  logic                  req;
  logic                  in_acc;
  logic                  is_hi;
  logic                  tc;
  logic [WORD_WIDTH-1:0] offset;
  logic [WORD_WIDTH-1:0] half_idx;

  assign req    = mem_read | mem_write;
  assign in_acc = (state_q == ST_ACC_LO) | (state_q == ST_ACC_HI);
  assign is_hi  = (state_q == ST_ACC_HI);

  sram_phase_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_d != state_q),
    .en_i (in_acc),
    .tc_o (tc)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_ACC_LO;
          wr_d    = mem_write;
        end
      end
      ST_ACC_LO: if (tc) state_d = ST_ACC_HI;
      ST_ACC_HI: if (tc) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Word index shifted left once; the half select fills bit 0.
  assign offset   = address - WORD_WIDTH'(MEM_BASE);
  assign half_idx = ((offset >> 2) << 1) | WORD_WIDTH'(is_hi);

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (in_acc) begin
      sram_addr = SRAM_ADDR_WIDTH'(half_idx);
      if (wr_q) begin
        sram_dq_oe  = 1'b1;
        sram_we_n   = tc;
        sram_dq_out = is_hi
          ? write_data[SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH]
          : write_data[0 +: SRAM_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      if (in_acc && !wr_q && tc) begin
        if (is_hi) begin
          read_data_q[SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH] <= sram_dq_in;
        end else begin
          read_data_q[0 +: SRAM_DATA_WIDTH] <= sram_dq_in;
        end
      end
    end
  end

  assign read_data = read_data_q;
  assign ready     = ~req | (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed and random
// loads/stores against a word-level memory model.
module tb_mem_stage_sram_ctrl;

  localparam int WC   = 5;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit [15:0] sram [0:1023];
  bit [31:0] ref_mem [0:511];
  logic [31:0] ref_rd = '0;

  mem_stage_sram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe)
      sram[sram_addr[9:0]] <= sram_dq_out;

  assign sram_dq_in = sram[sram_addr[9:0]];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    chk("ready_idle", 32'(ready), 32'd1);
  endtask

  // Issue one request and hold it until the DONE cycle is observed.
  task automatic access(input logic rd, input logic wr,
                        input int k, input logic [31:0] d,
                        output int done_cyc);
    int n;
    int we_lo;
    int we_hi;
    logic ok_lo;
    logic ok_hi;
    @(negedge clk);
    mem_read   = rd;
    mem_write  = wr;
    address    = 32'(BASE + 4 * k);
    write_data = d;
    #1;
    n = 0; we_lo = 0; we_hi = 0; ok_lo = 1'b1; ok_hi = 1'b1;
    while (!ready && n < 40) begin
      if (n >= 1 && n <= WC) begin
        if (sram_addr !== 18'(2 * k)) ok_lo = 1'b0;
        if (sram_dq_oe !== wr) ok_lo = 1'b0;
        if (wr && sram_dq_out !== d[15:0]) ok_lo = 1'b0;
        if (n == WC && sram_we_n !== 1'b1) ok_lo = 1'b0;
        if (!sram_we_n) we_lo++;
      end else if (n > WC && n <= 2 * WC) begin
        if (sram_addr !== 18'(2 * k + 1)) ok_hi = 1'b0;
        if (sram_dq_oe !== wr) ok_hi = 1'b0;
        if (wr && sram_dq_out !== d[31:16]) ok_hi = 1'b0;
        if (n == 2 * WC && sram_we_n !== 1'b1) ok_hi = 1'b0;
        if (!sram_we_n) we_hi++;
      end
      @(negedge clk);
      #1;
      n++;
    end
    done_cyc = cyc;
    if (wr) ref_mem[k] = d;
    else if (rd) ref_rd = ref_mem[k];
    chk("ready_low_cycles", 32'(n), 32'(2 * WC + 1));
    chk("lo_phase", 32'(ok_lo), 32'd1);
    chk("hi_phase", 32'(ok_hi), 32'd1);
    chk("we_lo_count", 32'(we_lo), wr ? 32'(WC - 1) : 32'd0);
    chk("we_hi_count", 32'(we_hi), wr ? 32'(WC - 1) : 32'd0);
    chk("done_addr", 32'(sram_addr), 32'd0);
    chk("read_data", read_data, ref_rd);
  endtask

  initial begin
    int d1;
    int d2;
    int op;
    int k;
    logic [31:0] d;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);

    access(1'b0, 1'b1, 2, 32'hDEADBEEF, d1);
    idle();
    chk("sram_lo_beef", 32'(sram[4]), 32'h0000BEEF);
    chk("sram_hi_dead", 32'(sram[5]), 32'h0000DEAD);

    access(1'b1, 1'b0, 2, 32'h0, d1);
    chk("load_deadbeef", read_data, 32'hDEADBEEF);
    idle();
    repeat (3) @(negedge clk);
    chk("load_stable", read_data, 32'hDEADBEEF);

    d = $urandom;
    access(1'b0, 1'b1, 7, d, d1);
    access(1'b1, 1'b0, 7, 32'h0, d2);
    chk("b2b_spacing", 32'(d2 - d1), 32'(2 * WC + 2));
    chk("b2b_load", read_data, d);
    idle();

    // Load of word 2, aborted by rst in its 3rd high-half cycle.
    @(negedge clk);
    mem_read = 1'b1;
    address  = 32'(BASE + 8);
    repeat (8) @(negedge clk);
    rst      = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    #1;
    ref_rd = '0;
    chk("abort_read_data", read_data, 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("abort_addr", 32'(sram_addr), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      op = int'($urandom_range(0, 2));
      k  = int'($urandom_range(0, 15));
      d  = $urandom;
      access(op != 1, op != 0, k, d, d1);
      idle();
    end

    access(1'b1, 1'b0, 2, 32'h0, d1);
    idle();
    access(1'b1, 1'b1, 0, 32'h1, d1);
    idle();
    chk("both_sram_lo", 32'(sram[0]), 32'h1);
    chk("both_sram_hi", 32'(sram[1]), 32'h0);
    access(1'b1, 1'b0, 0, 32'h0, d1);
    chk("both_readback", read_data, 32'h1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
